fabric_config_loader: RTL and testbench

- Bitstream configuration controller for the FPGA fabric.
- Accepts a stream of 32-bit words, detects the sync word, and parses frame headers.
- Assembles one full frame column (NumRows words) onto FrameData_o, then pulses the matching FrameStrobe_o bit for one cycle.
- Sits between the bitstream source (SPI/CPU loader) and the fabric; busy_o also drives the fabric warmboot reset, and configured_o releases fabric user logic.

---
 rtl/fabric_config_loader.sv | 141 ++++++++++++++
 tb/tb_fabric_config_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fabric_config_loader.sv
// fabric_config_loader: bitstream configuration controller for the FPGA fabric.
// Hunts for the sync word, parses frame headers, assembles one frame column of
// NumRows words onto FrameData_o and pulses the addressed FrameStrobe_o bit.
// Ports:
//   clk_i, rst_i         clock and synchronous active-high reset
//   bitstream_data_i     32-bit bitstream word
//   bitstream_valid_i    word qualifier (no backpressure)
//   busy_o               configuration in progress (HEADER or DATA state)
//   configured_o         desync seen, fabric user logic may run
//   FrameData_o          assembled frame, row r at [r*32 +: 32]
//   FrameStrobe_o        one-hot frame write strobe, bit = column*MaxFramesPerCol + frame
module fabric_config_loader #(
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned NumColumns      = 11,
    parameter int unsigned NumRows         = 16
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [31:0]                            bitstream_data_i,
    input  logic                                   bitstream_valid_i,
    output logic                                   busy_o,
    output logic                                   configured_o,
    output logic [FrameBitsPerRow*NumRows-1:0]     FrameData_o,
    output logic [MaxFramesPerCol*NumColumns-1:0]  FrameStrobe_o
);

    localparam int unsigned WordW   = 32;
    localparam int unsigned DataW   = FrameBitsPerRow * NumRows;
    localparam int unsigned StrobeW = MaxFramesPerCol * NumColumns;
    localparam int unsigned RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int unsigned AddrW   = 8;
    localparam int unsigned IdxW    = 16;

    localparam logic [WordW-1:0] Sync   = 32'hFAB0_FAB1;
    localparam logic [WordW-1:0] Desync = 32'hFAB0_FAB0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [RowW-1:0]      row_q, row_d;
    logic [AddrW-1:0]     col_q, col_d;
    logic [AddrW-1:0]     frame_q, frame_d;
    logic                 busy_q, busy_d;
    logic                 configured_q, configured_d;
    logic [DataW-1:0]     data_q, data_d;
    logic [StrobeW-1:0]   strobe_q, strobe_d;

    logic [IdxW-1:0]      strobe_idx;
    logic                 addr_in_range;

    // Strobe address of the frame currently being assembled
    assign strobe_idx    = IdxW'(col_q) * IdxW'(MaxFramesPerCol) + IdxW'(frame_q);
    assign addr_in_range = (col_q < AddrW'(NumColumns)) && (frame_q < AddrW'(MaxFramesPerCol));

    // Next-state and output computation
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        frame_d      = frame_q;
        configured_d = configured_q;
        data_d       = data_q;
        strobe_d     = '0;

        if (bitstream_valid_i) begin
            unique case (state_q)
                IDLE: begin
                    if (bitstream_data_i == Sync) begin
                        state_d      = HEADER;
                        configured_d = 1'b0;
                    end
                end
                HEADER: begin
                    if (bitstream_data_i == Desync) begin
                        state_d      = IDLE;
                        configured_d = 1'b1;
                    end else begin
                        col_d   = bitstream_data_i[15:8];
                        frame_d = bitstream_data_i[7:0];
                        row_d   = '0;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    for (int unsigned r = 0; r < NumRows; r++) begin
                        if (row_q == RowW'(r)) begin
                            data_d[r*WordW +: WordW] = bitstream_data_i;
                        end
                    end
                    if (row_q == RowW'(NumRows - 1)) begin
                        state_d = HEADER;
                        row_d   = '0;
                        // Out-of-range addresses consume the data but drop the frame
                        if (addr_in_range) begin
                            strobe_d = StrobeW'(1) << strobe_idx;
                        end
                    end else begin
                        row_d = row_q + RowW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            frame_q      <= '0;
            busy_q       <= 1'b0;
            configured_q <= 1'b0;
            data_q       <= '0;
            strobe_q     <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            frame_q      <= frame_d;
            busy_q       <= busy_d;
            configured_q <= configured_d;
            data_q       <= data_d;
            strobe_q     <= strobe_d;
        end
    end

    assign busy_o        = busy_q;
    assign configured_o  = configured_q;
    assign FrameData_o   = data_q;
    assign FrameStrobe_o = strobe_q;

endmodule

// File: tb/tb_fabric_config_loader.sv
// Directed bench for fabric_config_loader: reset, basic frame, gaps, boundary
// addressing, sync/desync aliasing in data, reconfiguration and mid-frame reset.
module tb_fabric_config_loader;

    localparam int unsigned DataW   = 512;
    localparam int unsigned StrobeW = 220;
    localparam logic [31:0] SYNC    = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC  = 32'hFAB0_FAB0;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic [31:0]        bitstream_data_i;
    logic               bitstream_valid_i;
    logic               busy_o;
    logic               configured_o;
    logic [DataW-1:0]   FrameData_o;
    logic [StrobeW-1:0] FrameStrobe_o;

    int errors = 0;
    int checks = 0;

    logic [DataW-1:0] exp_data;
    logic [31:0]      frame_words [16];

    fabric_config_loader dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .bitstream_data_i  (bitstream_data_i),
        .bitstream_valid_i (bitstream_valid_i),
        .busy_o            (busy_o),
        .configured_o      (configured_o),
        .FrameData_o       (FrameData_o),
        .FrameStrobe_o     (FrameStrobe_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [DataW-1:0] obs, input logic [DataW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [StrobeW-1:0] bit_of(input int idx);
        logic [StrobeW-1:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    // Present one word for one edge; returns 1 time unit after that edge
    task automatic send(input logic [31:0] w);
        bitstream_data_i  = w;
        bitstream_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        bitstream_valid_i = 1'b0;
        bitstream_data_i  = $urandom;
    endtask

    task automatic idle(input int n);
        bitstream_valid_i = 1'b0;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        bitstream_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        exp_data = '0;
    endtask

    // Header, then frame_words with optional random gaps; exp_bit < 0 means no strobe
    task automatic send_frame(input string tag, input logic [31:0] hdr, input int exp_bit,
                              input int max_gap, input bit tail_idle);
        send(hdr);
        check({tag, "_hdr_strobe"}, DataW'(FrameStrobe_o), '0);
        check({tag, "_hdr_data"}, FrameData_o, exp_data);
        for (int k = 0; k < 16; k++) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            send(frame_words[k]);
            exp_data[k*32 +: 32] = frame_words[k];
            if (k == 14) check({tag, "_early_strobe"}, DataW'(FrameStrobe_o), '0);
        end
        check({tag, "_strobe"}, DataW'(FrameStrobe_o), DataW'(bit_of(exp_bit)));
        check({tag, "_data"}, FrameData_o, exp_data);
        check({tag, "_busy"}, DataW'(busy_o), DataW'(1));
        if (tail_idle) begin
            idle(1);
            check({tag, "_strobe_1cyc"}, DataW'(FrameStrobe_o), '0);
        end
    endtask

    task automatic fill_words(input logic [31:0] base);
        for (int k = 0; k < 16; k++) frame_words[k] = base + 32'(k);
    endtask

    initial begin
        bitstream_data_i  = '0;
        bitstream_valid_i = 1'b0;
        exp_data          = '0;
        do_reset();

        // Reset state
        check("rst_busy", DataW'(busy_o), '0);
        check("rst_cfg", DataW'(configured_o), '0);
        check("rst_data", FrameData_o, '0);
        check("rst_strobe", DataW'(FrameStrobe_o), '0);

        // Non-sync words in IDLE are ignored
        send(32'h0000_0203);
        check("idle_ignore_busy", DataW'(busy_o), '0);
        send(DESYNC);
        check("idle_desync_cfg", DataW'(configured_o), '0);

        // Basic frame: column 2 frame 3 -> bit 43
        send(SYNC);
        check("basic_sync_busy", DataW'(busy_o), DataW'(1));
        check("basic_sync_cfg", DataW'(configured_o), '0);
        fill_words(32'h1000_0000);
        send_frame("basic", 32'h0000_0203, 43, 0, 1'b1);
        check("basic_row0", DataW'(FrameData_o[31:0]), DataW'(32'h1000_0000));
        check("basic_row15", DataW'(FrameData_o[511:480]), DataW'(32'h1000_000F));
        send(DESYNC);
        check("basic_desync_cfg", DataW'(configured_o), DataW'(1));
        check("basic_desync_busy", DataW'(busy_o), '0);

        // Same stream with gaps; reconfiguration clears configured_o
        send(SYNC);
        check("gap_sync_cfg", DataW'(configured_o), '0);
        check("gap_sync_busy", DataW'(busy_o), DataW'(1));
        fill_words(32'h2000_0000);
        send_frame("gaps", 32'hABCD_0203, 43, 3, 1'b1);
        idle(3);
        check("gaps_hold_busy", DataW'(busy_o), DataW'(1));
        check("gaps_hold_data", FrameData_o, exp_data);

        // Boundary addressing
        fill_words(32'h3000_0000);
        send_frame("col10_fr19", 32'h0000_0A13, 219, 0, 1'b1);
        fill_words(32'h3100_0000);
        send_frame("col11", 32'h0000_0B00, -1, 0, 1'b1);
        fill_words(32'h3200_0000);
        send_frame("fr20", 32'h0000_0014, -1, 0, 1'b1);
        fill_words(32'h3300_0000);
        send_frame("after_drop", 32'h0000_0001, 1, 0, 1'b1);
        // SYNC in HEADER is a header for column 0xFA: consumed, no strobe
        fill_words(32'h3400_0000);
        send_frame("sync_hdr", SYNC, -1, 0, 1'b1);

        // Sync/desync values inside frame data are plain data
        fill_words(32'h4000_0000);
        frame_words[3] = DESYNC;
        frame_words[5] = SYNC;
        send(32'h0000_0102);
        for (int k = 0; k < 16; k++) begin
            send(frame_words[k]);
            exp_data[k*32 +: 32] = frame_words[k];
            if (k == 3) check("alias_desync_cfg", DataW'(configured_o), '0);
            if (k == 5) check("alias_sync_busy", DataW'(busy_o), DataW'(1));
        end
        check("alias_strobe", DataW'(FrameStrobe_o), DataW'(bit_of(22)));
        check("alias_data", FrameData_o, exp_data);
        check("alias_row3", DataW'(FrameData_o[127:96]), DataW'(DESYNC));
        send(DESYNC);
        check("alias_end_cfg", DataW'(configured_o), DataW'(1));
        check("alias_end_busy", DataW'(busy_o), '0);

        // Reconfiguration: full column 5, 20 back-to-back frames -> bits 100..119
        send(SYNC);
        check("reconf_cfg", DataW'(configured_o), '0);
        check("reconf_busy", DataW'(busy_o), DataW'(1));
        for (int f = 0; f < 20; f++) begin
            fill_words(32'h5000_0000 + (32'(f) << 8));
            send_frame($sformatf("col5_fr%0d", f), 32'h0000_0500 | 32'(f), 100 + f, 0, 1'b0);
        end
        send(DESYNC);
        check("reconf_end_strobe", DataW'(FrameStrobe_o), '0);
        check("reconf_end_cfg", DataW'(configured_o), DataW'(1));

        // Mid-frame reset aborts the frame with no strobe
        send(SYNC);
        send(32'h0000_0000);
        for (int k = 0; k < 8; k++) send(32'h6000_0000 + 32'(k));
        do_reset();
        check("mid_rst_busy", DataW'(busy_o), '0);
        check("mid_rst_cfg", DataW'(configured_o), '0);
        check("mid_rst_data", FrameData_o, '0);
        check("mid_rst_strobe", DataW'(FrameStrobe_o), '0);
        for (int k = 0; k < 10; k++) begin
            send(32'h6000_0010 + 32'(k));
            check("mid_rst_strobe_hold", DataW'(FrameStrobe_o), '0);
        end
        check("mid_rst_ignore_busy", DataW'(busy_o), '0);
        check("mid_rst_ignore_data", FrameData_o, '0);
        send(SYNC);
        fill_words(32'h7000_0000);
        send_frame("post_rst", 32'h0000_0000, 0, 0, 1'b1);
        send(DESYNC);
        check("post_rst_cfg", DataW'(configured_o), DataW'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
